// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - command and column/row signal bundle for keypad_emulator
interface keypad_emulator_if #(
  parameter int HOLD_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic [3:0]        cols;
  logic [3:0]        rows;
  logic              busy;
  logic              key_down;
  logic              done;

  // Scanner / test side: offers commands and strobes columns
  modport master (
    output cmd_valid, cmd_key, cmd_hold, cols,
    input  cmd_ready, rows, busy, key_down, done
  );

  // Emulator side: accepts commands and returns rows
  modport slave (
    input  cmd_valid, cmd_key, cmd_hold, cols,
    output cmd_ready, rows, busy, key_down, done
  );
endinterface

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 keypad responder with command FIFO; contact bounce enabled by KEYPAD_EMU_BOUNCE_EN
module keypad_emulator #(
  parameter int FIFO_DEPTH    = 4,
  parameter int HOLD_W        = 16,
  parameter int GAP_CYCLES    = 16,
  parameter int BOUNCE_CYCLES = 8
) (
  input logic              clk,
  input logic              rst,
  keypad_emulator_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = 4 + HOLD_W;

  localparam logic [AW:0]        PTR_ONE  = 1;
  localparam logic [HOLD_W-1:0]  HOLD_ONE = 1;
  localparam logic [GW-1:0]      GAP_ONE  = 1;
  localparam logic [GW-1:0]      GAP_LOAD = GW'(GAP_CYCLES);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_param_check
      $error("keypad_emulator: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop;
  logic [3:0]        key_r, key_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic [3:0]        head_key;
  logic [HOLD_W-1:0] head_hold;
  logic [3:0]        row_hot;
  logic              col_hit;

  // The extra pointer bit separates full from empty when the low bits match
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;
  assign {head_key, head_hold} = mem[rd_ptr[AW-1:0]];

  assign bus.busy     = (state != IDLE) || !empty;
  assign bus.key_down = (state == PRESS);
  assign bus.done     = (state == GAP) && (gap_cnt == GAP_ONE);

  assign row_hot = 4'b0001 << key_r[1:0];
  assign col_hit = bus.cols[key_r[3:2]];

  // Command storage; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.cmd_key, bus.cmd_hold};
    end
  end

  // FIFO pointers; a push and a pop on the same edge both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // State, current key and phase counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_r    <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      key_r    <= key_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
    end
  end

  // Next state: pop a command, hold the key for its duration, then release for the gap
  always_comb begin
    state_n = state;
    key_n   = key_r;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          key_n   = head_key;
          hold_n  = (head_hold == '0) ? HOLD_ONE : head_hold;
          state_n = PRESS;
        end
      end
      PRESS: begin
        hold_n = hold_cnt - HOLD_ONE;
        if (hold_cnt == HOLD_ONE) begin
          gap_n   = GAP_LOAD;
          state_n = GAP;
        end
      end
      GAP: begin
        gap_n = gap_cnt - GAP_ONE;
        if (gap_cnt == GAP_ONE) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BW-1:0] BOUNCE_LEN = BW'(BOUNCE_CYCLES);
  localparam logic [BW-1:0] PH_ONE     = 1;

  logic [7:0]    lfsr;
  logic [BW-1:0] ph_cnt;
  logic          bounce;

  assign bounce = (ph_cnt < BOUNCE_LEN);

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Cycles spent in the current phase, restarted on every state change, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt <= '0;
    end else if (state_n != state) begin
      ph_cnt <= '0;
    end else if (ph_cnt != BOUNCE_LEN) begin
      ph_cnt <= ph_cnt + PH_ONE;
    end
  end

  // Row response with chatter at the start of both the closure and the release
  always_comb begin
    bus.rows = 4'b0000;
    if (state == PRESS && col_hit) begin
      bus.rows = (bounce && !lfsr[0]) ? 4'b0000 : row_hot;
    end else if (state == GAP && col_hit && bounce && lfsr[0]) begin
      bus.rows = row_hot;
    end
  end
`else
  // Clean row response: follows the strobed column with no added latency
  always_comb begin
    bus.rows = 4'b0000;
    if (state == PRESS && col_hit) begin
      bus.rows = row_hot;
    end
  end
`endif

endmodule
